button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_MS, default 20, meaning the number of clock1KHz cycles a synchronized level must stay stable before it is accepted; legal range 2..31.
REQ-002 SHALL have port clock1KHz  input  1  1 kHz scan clock; all state changes on the rising edge.
REQ-003 SHALL have port RAMclr  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port btn_n  input  2  raw push-buttons, active-low, asynchronous to clock1KHz.
REQ-005 SHALL have port clr_tgl  input  1  sticky-flag clear request; the consumer toggles it once per request, from a foreign clock domain.
REQ-006 SHALL have port clr_ack  output  1  clear acknowledge; equals the synchronized clr_tgl once the clear is done.
REQ-007 SHALL have port btn_state  output  2  debounced level per button, 1 = pressed.
REQ-008 SHALL have port btn_press  output  2  sticky per-button press-event flag.
REQ-009 SHALL have port status  output  16  word for the CPU button RAM slot: {cnt1[3:0], cnt0[3:0], 4'b0000, btn_press[1:0], btn_state[1:0]}.

Function
REQ-010 SHALL invert btn_n and pass each bit through a 2-flop synchronizer before any decision logic.
REQ-011 SHALL run, per button, an FSM with states RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND, each with a 5-bit stability counter.
REQ-012 RELEASED: if the synchronized input is 1 -> PRESS_PEND with cnt=0; otherwise stay.
REQ-013 PRESS_PEND: if the input is 0 -> RELEASED; if cnt==DEBOUNCE_MS-1 -> PRESSED; otherwise cnt+1.
REQ-014 PRESSED: if the input is 0 -> RELEASE_PEND with cnt=0; otherwise stay.
REQ-015 RELEASE_PEND: if the input is 1 -> PRESSED; if cnt==DEBOUNCE_MS-1 -> RELEASED; otherwise cnt+1.
REQ-016 btn_state SHALL be registered and equal 1 exactly in PRESSED and RELEASE_PEND.
REQ-017 Latency: with a raw level held from the first rising edge that samples it, btn_state SHALL change after rising edge DEBOUNCE_MS+3; for DEBOUNCE_MS=20 that is edge 23.
REQ-018 Glitches shorter than DEBOUNCE_MS+1 cycles after synchronization SHALL produce no btn_state change.
REQ-019 On each PRESS_PEND->PRESSED transition: set btn_press[i], and increment the 4-bit press counter cnt[i], wrapping 15->0.
REQ-020 clr_tgl SHALL be synchronized by 2 flops into clock1KHz; a third flop holds the previous value, and a mismatch between them marks a clear event.
REQ-021 On a clear event: btn_press SHALL go to 00 on that edge, and clr_ack SHALL take the synchronized clr_tgl value on the same edge.
REQ-022 A press event and a clear event on the same edge: the set SHALL win for that button; other buttons clear normally.
REQ-023 cnt[i] SHALL NOT be affected by clears; it is cleared only by reset.
REQ-024 status SHALL be a purely combinational concatenation of registered values.
REQ-025 A clr_tgl toggle issued before the previous clr_ack matches SHALL be treated as undefined; the consumer waits for clr_ack==clr_tgl.

Reset
REQ-026 RAMclr high SHALL asynchronously force: all synchronizer flops 0, both FSMs RELEASED, cnt=0, btn_state=00, btn_press=00, counters=0, status=16'h0000.
REQ-027 After reset, the clr_tgl previous-value flop is 0 and clr_ack=0; a consumer with clr_tgl=1 at reset gets exactly one clear event.
REQ-028 Reset during PRESS_PEND or RELEASE_PEND SHALL abandon the debounce with no event generated; after release, a still-held button re-debounces from RELEASED.

Structure
REQ-029 A shared package SHALL hold:
- the FSM state encoding (2-bit enum),
- the DEBOUNCE_MS default,
- the status field bit positions.
REQ-030 Per-button logic SHALL be sub-module btn_debounce_fsm (sync, FSM, counter, press pulse out), instantiated twice; the flags, press counters and clear handshake stay in the top.

Verification
REQ-031 btn_n[0] driven 0 from edge 0 with DEBOUNCE_MS=20 -> btn_state=01, btn_press=01, status=16'h0105 after edge 23, none earlier.
REQ-032 btn_n[1] low pulse of 10 cycles, then high -> btn_state, btn_press and cnt1 stay 0 throughout.
REQ-033 16 clean presses of button 0 -> cnt0 counts 1..15 then 0, btn_press[0] stays 1.
REQ-034 Toggle clr_tgl 0->1 while btn_press=11 -> within 3 edges btn_press=00 and clr_ack=1; cnt0/cnt1 unchanged.
REQ-035 Clear event on the same edge as a button 1 press completes -> btn_press=10 afterwards, clr_ack follows.
REQ-036 Assert RAMclr at debounce cycle 12 with the button still held -> outputs 0 immediately; after release, btn_state rises 23 edges later.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// ---------------------------------------------------------------------------
// button_debouncer_pkg
// Shared definitions for the two-button debouncer:
//   - btn_fsm_state_e : per-button debounce FSM encoding (2-bit)
//   - DEBOUNCE_MS_DEFAULT : default stability window in clock1KHz cycles
//   - STATUS_*_LSB : bit positions of the fields in the 16-bit status word
// ---------------------------------------------------------------------------
package button_debouncer_pkg;

    // The encoding is chosen so that bit 1 is set exactly in the two states
    // where the button counts as pressed. The debounced level is then the
    // state register's MSB, with no extra decode logic.
    typedef enum logic [1:0] {
        RELEASED     = 2'b00,
        PRESS_PEND   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_PEND = 2'b11
    } btn_fsm_state_e;

    localparam int DEBOUNCE_MS_DEFAULT = 20;

    // Status word layout: {cnt1, cnt0, 4'b0000, btn_press[1:0], btn_state[1:0]}
    localparam int STATUS_STATE_LSB = 0;
    localparam int STATUS_PRESS_LSB = 2;
    localparam int STATUS_CNT0_LSB  = 8;
    localparam int STATUS_CNT1_LSB  = 12;

endpackage

// File: rtl/button_debouncer_fsm.sv
// ---------------------------------------------------------------------------
// btn_debounce_fsm
// Debouncer for one button. It synchronizes the raw level and runs the
// RELEASED / PRESS_PEND / PRESSED / RELEASE_PEND FSM with a stability counter.
// Ports:
//   clock1KHz   : 1 kHz scan clock, rising edge
//   RAMclr      : asynchronous active-high reset
//   btn         : raw button level, active-high (already inverted), asynchronous
//   btn_state   : debounced level, 1 = pressed (registered)
//   press_pulse : one-cycle strobe, high during the cycle whose rising edge
//                 completes PRESS_PEND -> PRESSED
// ---------------------------------------------------------------------------
module btn_debounce_fsm
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT
) (
    input  logic clock1KHz,
    input  logic RAMclr,
    input  logic btn,
    output logic btn_state,
    output logic press_pulse
);

    localparam logic [4:0] CNT_LAST = 5'(DEBOUNCE_MS - 1);

    logic [1:0]     sync;
    logic           level;
    btn_fsm_state_e state, state_nxt;
    logic [4:0]     cnt, cnt_nxt;

    // Two-flop synchronizer. The raw button is asynchronous to the scan clock,
    // so nothing downstream may look at it before the second flop.
    always_ff @(posedge clock1KHz or posedge RAMclr) begin
        if (RAMclr) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], btn};
        end
    end

    assign level = sync[1];

    // State and stability counter registers. Reset drops any debounce that is
    // in progress, so a button that is still held starts again from RELEASED.
    always_ff @(posedge clock1KHz or posedge RAMclr) begin
        if (RAMclr) begin
            state <= RELEASED;
            cnt   <= 5'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic. In each pending state, a level that flips back returns
    // to the stable state at once. A level that holds for DEBOUNCE_MS counts is
    // accepted. The press strobe is raised on the accepting transition so that
    // the top can set its flag and counter on the same edge.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_pulse = 1'b0;
        case (state)
            RELEASED: begin
                if (level) begin
                    state_nxt = PRESS_PEND;
                    cnt_nxt   = 5'd0;
                end
            end
            PRESS_PEND: begin
                if (!level) begin
                    state_nxt = RELEASED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = PRESSED;
                    press_pulse = 1'b1;
                end else begin
                    cnt_nxt = cnt + 5'd1;
                end
            end
            PRESSED: begin
                if (!level) begin
                    state_nxt = RELEASE_PEND;
                    cnt_nxt   = 5'd0;
                end
            end
            RELEASE_PEND: begin
                if (level) begin
                    state_nxt = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = RELEASED;
                end else begin
                    cnt_nxt = cnt + 5'd1;
                end
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = 5'd0;
            end
        endcase
    end

    assign btn_state = state[1];

endmodule

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
// Two-button debouncer for the CPU button RAM slot. Each button has a sticky
// press flag and a 4-bit press counter. The press flags are cleared through a
// toggle handshake that comes from a foreign clock domain.
// Ports:
//   clock1KHz : 1 kHz scan clock, rising edge
//   RAMclr    : asynchronous active-high reset
//   btn_n     : [1:0] raw buttons, active-low, asynchronous
//   clr_tgl   : clear request; the consumer toggles it once per request
//   clr_ack   : equals the synchronized clr_tgl after the clear is done
//   btn_state : [1:0] debounced level, 1 = pressed
//   btn_press : [1:0] sticky press-event flags
//   status    : {cnt1, cnt0, 4'b0000, btn_press, btn_state}
// ---------------------------------------------------------------------------
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT
) (
    input  logic        clock1KHz,
    input  logic        RAMclr,
    input  logic [1:0]  btn_n,
    input  logic        clr_tgl,
    output logic        clr_ack,
    output logic [1:0]  btn_state,
    output logic [1:0]  btn_press,
    output logic [15:0] status
);

    logic [1:0]      btn_raw;
    logic [1:0]      press_pulse;
    logic [1:0][3:0] press_cnt;
    logic [1:0]      clr_sync;
    logic            clr_prev;
    logic            clear_evt;

    assign btn_raw = ~btn_n;

    // One debouncer per button. Each one owns its synchronizer and FSM.
    for (genvar i = 0; i < 2; i++) begin : g_btn
        btn_debounce_fsm #(
            .DEBOUNCE_MS (DEBOUNCE_MS)
        ) u_fsm (
            .clock1KHz   (clock1KHz),
            .RAMclr      (RAMclr),
            .btn         (btn_raw[i]),
            .btn_state   (btn_state[i]),
            .press_pulse (press_pulse[i])
        );
    end

    // Clear handshake. clr_tgl passes through two flops. A third flop holds
    // the previous synchronized value, so any toggle gives exactly one cycle
    // of mismatch. Because the previous-value flop resets to 0, a consumer
    // that holds clr_tgl=1 through reset sees one clear after reset.
    always_ff @(posedge clock1KHz or posedge RAMclr) begin
        if (RAMclr) begin
            clr_sync <= 2'b00;
            clr_prev <= 1'b0;
            clr_ack  <= 1'b0;
        end else begin
            clr_sync <= {clr_sync[0], clr_tgl};
            clr_prev <= clr_sync[1];
            if (clear_evt) begin
                clr_ack <= clr_sync[1];
            end
        end
    end

    assign clear_evt = clr_sync[1] ^ clr_prev;

    // Sticky press flags and press counters. A press that completes on the
    // same edge as a clear keeps its flag set, so that press event is not lost.
    // The counters ignore clears and wrap from 15 to 0.
    always_ff @(posedge clock1KHz or posedge RAMclr) begin
        if (RAMclr) begin
            btn_press <= 2'b00;
            press_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (press_pulse[i]) begin
                    btn_press[i] <= 1'b1;
                    press_cnt[i] <= press_cnt[i] + 4'd1;
                end else if (clear_evt) begin
                    btn_press[i] <= 1'b0;
                end
            end
        end
    end

    // The status word is built only from register outputs, so it settles
    // right after each edge and drops to zero at once on reset.
    always_comb begin
        status = 16'h0000;
        status[STATUS_STATE_LSB +: 2] = btn_state;
        status[STATUS_PRESS_LSB +: 2] = btn_press;
        status[STATUS_CNT0_LSB  +: 4] = press_cnt[0];
        status[STATUS_CNT1_LSB  +: 4] = press_cnt[1];
    end

endmodule

// File: tb/tb_button_debouncer.sv
// ---------------------------------------------------------------------------
// tb_button_debouncer
// Directed testbench for button_debouncer with DEBOUNCE_MS = 20. Inputs are
// driven 1 time unit after a rising edge, and outputs are sampled at the same
// point. The edge that follows a stimulus change is the first edge to sample it.
// ---------------------------------------------------------------------------
module tb_button_debouncer;

    logic        clock1KHz = 1'b0;
    logic        RAMclr;
    logic [1:0]  btn_n;
    logic        clr_tgl;
    logic        clr_ack;
    logic [1:0]  btn_state;
    logic [1:0]  btn_press;
    logic [15:0] status;

    int tests    = 0;
    int failures = 0;

    button_debouncer #(
        .DEBOUNCE_MS (20)
    ) dut (
        .clock1KHz (clock1KHz),
        .RAMclr    (RAMclr),
        .btn_n     (btn_n),
        .clr_tgl   (clr_tgl),
        .clr_ack   (clr_ack),
        .btn_state (btn_state),
        .btn_press (btn_press),
        .status    (status)
    );

    // Free-running scan clock, period 10.
    always #5 clock1KHz = ~clock1KHz;

    // Advance n rising edges and stop 1 unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clock1KHz);
        #1;
    endtask

    // Drive the button and clear-request inputs.
    task automatic applyStimulus(input logic [1:0] btns, input logic clr);
        btn_n   = btns;
        clr_tgl = clr;
    endtask

    // Compare one observed value with its expected value and count the result.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Stimulus and checks run as one linear sequence of directed steps.
    initial begin
        logic [15:0] expv;

        // Reset state
        RAMclr = 1'b1;
        applyStimulus(2'b11, 1'b0);
        #3;
        checkOutput("reset_status", status, 16'h0000);
        checkOutput("reset_ack", {15'd0, clr_ack}, 16'h0000);
        tick(2);
        RAMclr = 1'b0;
        tick(2);
        checkOutput("idle_status", status, 16'h0000);

        // Button 0 held: nothing may change before edge 23
        applyStimulus(2'b10, 1'b0);
        for (int e = 1; e <= 22; e++) begin
            tick(1);
            checkOutput("b0_pending", status, 16'h0000);
        end
        tick(1);
        checkOutput("b0_state", {14'd0, btn_state}, 16'h0001);
        checkOutput("b0_press", {14'd0, btn_press}, 16'h0001);
        checkOutput("b0_status", status, 16'h0105);

        // Release button 0: same 23-edge latency, press flag stays set
        applyStimulus(2'b11, 1'b0);
        tick(22);
        checkOutput("b0_rel_pending", status, 16'h0105);
        tick(1);
        checkOutput("b0_released", status, 16'h0104);

        // 10-cycle glitch on button 1 must not register
        applyStimulus(2'b01, 1'b0);
        for (int e = 1; e <= 10; e++) begin
            tick(1);
            checkOutput("b1_glitch_low", status, 16'h0104);
        end
        applyStimulus(2'b11, 1'b0);
        for (int e = 1; e <= 30; e++) begin
            tick(1);
            checkOutput("b1_glitch_after", status, 16'h0104);
        end

        // Clean press and release of button 1
        applyStimulus(2'b01, 1'b0);
        tick(22);
        checkOutput("b1_pending", status, 16'h0104);
        tick(1);
        checkOutput("b1_pressed", status, 16'h110E);
        applyStimulus(2'b11, 1'b0);
        tick(23);
        checkOutput("b1_released", status, 16'h110C);

        // Clear with both flags set: takes effect on the third edge
        applyStimulus(2'b11, 1'b1);
        tick(2);
        checkOutput("clr_wait_status", status, 16'h110C);
        checkOutput("clr_wait_ack", {15'd0, clr_ack}, 16'h0000);
        tick(1);
        checkOutput("clr_done_status", status, 16'h1100);
        checkOutput("clr_done_ack", {15'd0, clr_ack}, 16'h0001);
        tick(5);
        checkOutput("clr_stable", status, 16'h1100);

        // Reset with clr_tgl held at 1: exactly one clear event afterwards
        RAMclr = 1'b1;
        #1;
        checkOutput("reset2_status", status, 16'h0000);
        checkOutput("reset2_ack", {15'd0, clr_ack}, 16'h0000);
        tick(1);
        RAMclr = 1'b0;
        tick(2);
        checkOutput("post_reset_ack_wait", {15'd0, clr_ack}, 16'h0000);
        tick(1);
        checkOutput("post_reset_ack", {15'd0, clr_ack}, 16'h0001);
        checkOutput("post_reset_status", status, 16'h0000);

        // 16 presses of button 0: counter goes 1..15 then wraps to 0
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(2'b10, 1'b1);
            tick(23);
            expv = 16'((k % 16) << 8) | 16'h0005;
            checkOutput("wrap_pressed", status, expv);
            applyStimulus(2'b11, 1'b1);
            tick(23);
            expv = 16'((k % 16) << 8) | 16'h0004;
            checkOutput("wrap_released", status, expv);
        end

        // Clear event on the same edge as the button 1 press: set wins for button 1
        applyStimulus(2'b01, 1'b1);
        tick(20);
        applyStimulus(2'b01, 1'b0);
        tick(2);
        checkOutput("race_before", status, 16'h0004);
        checkOutput("race_before_ack", {15'd0, clr_ack}, 16'h0001);
        tick(1);
        checkOutput("race_status", status, 16'h100A);
        checkOutput("race_press", {14'd0, btn_press}, 16'h0002);
        checkOutput("race_ack", {15'd0, clr_ack}, 16'h0000);
        applyStimulus(2'b11, 1'b0);
        tick(23);
        checkOutput("race_released", status, 16'h1008);

        // Reset at debounce count 12 with button 0 still held
        applyStimulus(2'b10, 1'b0);
        tick(15);
        checkOutput("abort_pending", status, 16'h1008);
        #2;
        RAMclr = 1'b1;
        #1;
        checkOutput("abort_status", status, 16'h0000);
        checkOutput("abort_ack", {15'd0, clr_ack}, 16'h0000);
        tick(1);
        RAMclr = 1'b0;
        tick(22);
        checkOutput("redebounce_pending", status, 16'h0000);
        tick(1);
        checkOutput("redebounce_done", status, 16'h0105);
        checkOutput("redebounce_ack", {15'd0, clr_ack}, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
